// File: rtl/stack_seq_pkg.sv
// Shared types and constants for the stack sequencer.
// Op codes, FSM state encoding, and data-path widths live here so that the
// top level and the bounds checker agree on them.
package stack_seq_pkg;

   localparam int DATA_W = 16;
   localparam int OP_W   = 3;

   // Stack operations; codes 6 and 7 are deliberately left unassigned (illegal)
   typedef enum logic [OP_W-1:0] {
      OP_PUSH = 3'd0,
      OP_POP  = 3'd1,
      OP_CALL = 3'd2,
      OP_RET  = 3'd3,
      OP_XTHL = 3'd4,
      OP_SPHL = 3'd5
   } op_code_t;

   // Sequencer states: one resync cycle after reset, then a fixed 4-cycle op loop
   typedef enum logic [2:0] {
      SYNC  = 3'd0,
      IDLE  = 3'd1,
      ISSUE = 3'd2,
      WAIT  = 3'd3,
      DONE  = 3'd4
   } seq_state_t;

   // True for the six defined op codes
   function automatic logic op_is_legal(input logic [OP_W-1:0] code);
      return (code <= OP_SPHL);
   endfunction

   // True for ops whose completion carries a word read back from memory
   function automatic logic op_reads_mem(input logic [OP_W-1:0] code);
      return (code == OP_POP) || (code == OP_RET) || (code == OP_XTHL);
   endfunction

endpackage

// File: rtl/stack_seq_bounds.sv
// Stack bounds checker for the stack sequencer.
// Flags a push-type op that would take the stack pointer below the floor,
// or a pop-type op that would take it above the reset (empty) position.
// Only instantiated when STACK_SEQ_BOUNDS_EN is defined.
module stack_seq_bounds
   import stack_seq_pkg::*;
#(
   parameter logic [DATA_W-1:0] SP_RESET    = 16'hFFFF,
   parameter logic [DATA_W-1:0] STACK_FLOOR = 16'hC000
) (
   input  logic [OP_W-1:0]   op_code,
   input  logic [DATA_W-1:0] sp_value,
   output logic              reject
);

   // Limits are widened by one bit so that FLOOR+2 cannot wrap to a small value
   localparam logic [DATA_W:0] PUSH_LIMIT = {1'b0, STACK_FLOOR} + 17'd2;
   localparam logic [DATA_W:0] POP_LIMIT  = {1'b0, SP_RESET} - 17'd2;

   logic [DATA_W:0] sp_wide;

   assign sp_wide = {1'b0, sp_value};

   // Decide whether the requested op would overflow or underflow the stack region
   always_comb begin
      reject = 1'b0;
      case (op_code)
         OP_PUSH, OP_CALL: reject = (sp_wide < PUSH_LIMIT);
         OP_POP,  OP_RET:  reject = (sp_wide > POP_LIMIT);
         default:          reject = 1'b0;
      endcase
   end

endmodule

// File: rtl/stack_sequencer.sv
// Stack sequencer: accepts one stack op at a time, drives a single strobe to
// the memory stack port, tracks a shadow stack pointer and reports completion.
// Optional build macro STACK_SEQ_BOUNDS_EN adds stack-region bounds checking.
module stack_sequencer
   import stack_seq_pkg::*;
#(
   parameter logic [DATA_W-1:0] SP_RESET    = 16'hFFFF,
   parameter logic [DATA_W-1:0] STACK_FLOOR = 16'hC000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              op_valid,
   output logic              op_ready,
   input  logic [OP_W-1:0]   op_code,
   input  logic [DATA_W-1:0] op_data,
   output logic              done,
   output logic [DATA_W-1:0] result_data,
   output logic              err,
   output logic [DATA_W-1:0] sp_value,
   output logic              mem_push,
   output logic              mem_pop,
   output logic              mem_swap,
   output logic              mem_replace_sp,
   output logic [DATA_W-1:0] mem_input_data,
   input  logic [DATA_W-1:0] mem_out
);

   seq_state_t        state;
   seq_state_t        state_next;
   logic              sync_armed;
   logic [OP_W-1:0]   op_q;
   logic [DATA_W-1:0] data_q;
   logic              err_q;
   logic [DATA_W-1:0] result_q;
   logic [DATA_W-1:0] sp_q;
   logic              bounds_reject;
   logic              accept;

   assign accept = (state == IDLE) && op_valid;

`ifdef STACK_SEQ_BOUNDS_EN
   stack_seq_bounds #(
      .SP_RESET    (SP_RESET),
      .STACK_FLOOR (STACK_FLOOR)
   ) u_bounds (
      .op_code  (op_code),
      .sp_value (sp_q),
      .reject   (bounds_reject)
   );
`else
   // Without bounds checking the floor has no effect on the logic
   logic unused_floor;
   assign unused_floor  = ^STACK_FLOOR;
   assign bounds_reject = 1'b0;
`endif

   // State register; reset parks the FSM in SYNC until the port is resynchronised
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= SYNC;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: SYNC lasts until its strobe has fired, then a fixed op loop
   always_comb begin
      state_next = state;
      case (state)
         SYNC:    state_next = sync_armed ? IDLE : SYNC;
         IDLE:    state_next = op_valid ? ISSUE : IDLE;
         ISSUE:   state_next = WAIT;
         WAIT:    state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = SYNC;
      endcase
   end

   // The SYNC strobe is held back one edge so it spans a full clock after reset release
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_armed <= 1'b0;
      end else begin
         sync_armed <= (state == SYNC);
      end
   end

   // Capture the accepted op and decide up front whether it will be rejected
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_q   <= OP_PUSH;
         data_q <= SP_RESET;
         err_q  <= 1'b0;
      end else if (accept) begin
         op_q   <= op_code;
         data_q <= op_data;
         err_q  <= !op_is_legal(op_code) || bounds_reject;
      end
   end

   // Shadow stack pointer moves on the edge that ends ISSUE; rejected ops leave it alone
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sp_q <= SP_RESET;
      end else if ((state == ISSUE) && !err_q) begin
         case (op_q)
            OP_PUSH, OP_CALL: sp_q <= sp_q - 16'd2;
            OP_POP,  OP_RET:  sp_q <= sp_q + 16'd2;
            OP_SPHL:          sp_q <= data_q;
            default:          sp_q <= sp_q;
         endcase
      end
   end

   // Result is cleared on accept and only picks up memory data for reading ops
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         result_q <= '0;
      end else if (accept) begin
         result_q <= '0;
      end else if ((state == WAIT) && !err_q && op_reads_mem(op_q)) begin
         result_q <= mem_out;
      end
   end

   // Output decode: strobes only in SYNC and ISSUE, and never more than one at a time
   always_comb begin
      mem_push       = 1'b0;
      mem_pop        = 1'b0;
      mem_swap       = 1'b0;
      mem_replace_sp = 1'b0;
      mem_input_data = data_q;
      op_ready       = 1'b0;
      done           = 1'b0;
      err            = 1'b0;
      case (state)
         SYNC: begin
            mem_input_data = SP_RESET;
            mem_replace_sp = sync_armed;
         end
         IDLE: begin
            op_ready = 1'b1;
         end
         ISSUE: begin
            if (!err_q) begin
               case (op_q)
                  OP_PUSH, OP_CALL: mem_push       = 1'b1;
                  OP_POP,  OP_RET:  mem_pop        = 1'b1;
                  OP_XTHL:          mem_swap       = 1'b1;
                  OP_SPHL:          mem_replace_sp = 1'b1;
                  default:          mem_push       = 1'b0;
               endcase
            end
         end
         DONE: begin
            done = 1'b1;
            err  = err_q;
         end
         default: begin
            done = 1'b0;
         end
      endcase
   end

   assign result_data = result_q;
   assign sp_value    = sp_q;

endmodule

// File: tb/tb_stack_sequencer.sv
// Directed testbench for stack_sequencer.
// Walks reset/resync, PUSH, POP, XTHL, SPHL, a floor-crossing PUSH, an
// illegal code, an ignored request and a mid-op reset, checking each cycle.
module tb_stack_sequencer;

   logic        clk;
   logic        reset;
   logic        op_valid;
   logic        op_ready;
   logic [2:0]  op_code;
   logic [15:0] op_data;
   logic        done;
   logic [15:0] result_data;
   logic        err;
   logic [15:0] sp_value;
   logic        mem_push;
   logic        mem_pop;
   logic        mem_swap;
   logic        mem_replace_sp;
   logic [15:0] mem_input_data;
   logic [15:0] mem_out;

   int passCount  = 0;
   int checkCount = 0;

   logic [15:0] expPushStrobe;
   logic [15:0] expPushSp;
   logic [15:0] expPushErr;

   stack_sequencer dut (
      .clk            (clk),
      .reset          (reset),
      .op_valid       (op_valid),
      .op_ready       (op_ready),
      .op_code        (op_code),
      .op_data        (op_data),
      .done           (done),
      .result_data    (result_data),
      .err            (err),
      .sp_value       (sp_value),
      .mem_push       (mem_push),
      .mem_pop        (mem_pop),
      .mem_swap       (mem_swap),
      .mem_replace_sp (mem_replace_sp),
      .mem_input_data (mem_input_data),
      .mem_out        (mem_out)
   );

   // Free-running 10-unit clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case the sequence ever stalls
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed timeout required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Advance one clock and settle just after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Strobe vector {push, pop, swap, replace_sp} zero-extended for comparison
   function automatic logic [15:0] strobes();
      return {12'h000, mem_push, mem_pop, mem_swap, mem_replace_sp};
   endfunction

   task automatic checkOutput(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
      checkCount++;
      assert (observed === expected) passCount++;
      else $error("[TB] FAIL %s: observed %h required %h", tag, observed, expected);
   endtask

   // Present one op in IDLE and step across its accept edge into ISSUE
   task automatic applyStimulus(input logic [2:0] code, input logic [15:0] data);
      op_valid = 1'b1;
      op_code  = code;
      op_data  = data;
      tick();
      op_valid = 1'b0;
   endtask

   initial begin
`ifdef STACK_SEQ_BOUNDS_EN
      expPushStrobe = 16'h0000;
      expPushSp     = 16'hC001;
      expPushErr    = 16'h0001;
`else
      expPushStrobe = 16'h0008;
      expPushSp     = 16'hBFFF;
      expPushErr    = 16'h0000;
`endif
      reset    = 1'b1;
      op_valid = 1'b0;
      op_code  = 3'd0;
      op_data  = 16'h0000;
      mem_out  = 16'h0000;
      repeat (3) tick();

      $display("[TB] reset state");
      checkOutput("rst_strobes", strobes(), 16'h0000);
      checkOutput("rst_sp", sp_value, 16'hFFFF);
      checkOutput("rst_mid", mem_input_data, 16'hFFFF);
      checkOutput("rst_done", {15'h0, done}, 16'h0000);
      checkOutput("rst_err", {15'h0, err}, 16'h0000);
      checkOutput("rst_result", result_data, 16'h0000);
      checkOutput("rst_ready", {15'h0, op_ready}, 16'h0000);

      reset = 1'b0;
      tick();
      checkOutput("sync_strobes", strobes(), 16'h0001);
      checkOutput("sync_mid", mem_input_data, 16'hFFFF);
      checkOutput("sync_ready", {15'h0, op_ready}, 16'h0000);
      tick();
      checkOutput("idle_strobes", strobes(), 16'h0000);
      checkOutput("idle_ready", {15'h0, op_ready}, 16'h0001);
      checkOutput("idle_sp", sp_value, 16'hFFFF);

      $display("[TB] PUSH 1234");
      applyStimulus(3'd0, 16'h1234);
      checkOutput("push_issue_strobes", strobes(), 16'h0008);
      checkOutput("push_issue_mid", mem_input_data, 16'h1234);
      checkOutput("push_issue_sp", sp_value, 16'hFFFF);
      checkOutput("push_issue_ready", {15'h0, op_ready}, 16'h0000);
      tick();
      checkOutput("push_wait_strobes", strobes(), 16'h0000);
      checkOutput("push_wait_sp", sp_value, 16'hFFFD);
      checkOutput("push_wait_done", {15'h0, done}, 16'h0000);
      tick();
      checkOutput("push_done", {15'h0, done}, 16'h0001);
      checkOutput("push_err", {15'h0, err}, 16'h0000);
      checkOutput("push_result", result_data, 16'h0000);
      tick();
      checkOutput("push_after_done", {15'h0, done}, 16'h0000);
      checkOutput("push_after_ready", {15'h0, op_ready}, 16'h0001);

      $display("[TB] POP");
      mem_out = 16'h1234;
      applyStimulus(3'd1, 16'h0000);
      checkOutput("pop_issue_strobes", strobes(), 16'h0004);
      checkOutput("pop_issue_done", {15'h0, done}, 16'h0000);
      tick();
      checkOutput("pop_wait_sp", sp_value, 16'hFFFF);
      checkOutput("pop_wait_done", {15'h0, done}, 16'h0000);
      tick();
      checkOutput("pop_done", {15'h0, done}, 16'h0001);
      checkOutput("pop_result", result_data, 16'h1234);
      checkOutput("pop_err", {15'h0, err}, 16'h0000);
      tick();

      $display("[TB] XTHL BEEF");
      mem_out = 16'h00AA;
      applyStimulus(3'd4, 16'hBEEF);
      checkOutput("xthl_strobes", strobes(), 16'h0002);
      checkOutput("xthl_mid", mem_input_data, 16'hBEEF);
      tick();
      checkOutput("xthl_sp", sp_value, 16'hFFFF);
      tick();
      checkOutput("xthl_done", {15'h0, done}, 16'h0001);
      checkOutput("xthl_result", result_data, 16'h00AA);
      tick();

      $display("[TB] SPHL C001");
      applyStimulus(3'd5, 16'hC001);
      checkOutput("sphl_strobes", strobes(), 16'h0001);
      checkOutput("sphl_mid", mem_input_data, 16'hC001);
      tick();
      checkOutput("sphl_sp", sp_value, 16'hC001);
      tick();
      checkOutput("sphl_done", {15'h0, done}, 16'h0001);
      checkOutput("sphl_result", result_data, 16'h0000);
      checkOutput("sphl_err", {15'h0, err}, 16'h0000);
      tick();

      $display("[TB] PUSH at floor");
      applyStimulus(3'd0, 16'h5555);
      checkOutput("floor_strobes", strobes(), expPushStrobe);
      tick();
      checkOutput("floor_sp", sp_value, expPushSp);
      tick();
      checkOutput("floor_done", {15'h0, done}, 16'h0001);
      checkOutput("floor_err", {15'h0, err}, expPushErr);
      tick();

      $display("[TB] illegal op 7 with ignored request");
      applyStimulus(3'd7, 16'h1111);
      checkOutput("ill_strobes", strobes(), 16'h0000);
      op_valid = 1'b1;
      op_code  = 3'd0;
      op_data  = 16'h2222;
      tick();
      checkOutput("ill_sp", sp_value, expPushSp);
      checkOutput("ill_ready", {15'h0, op_ready}, 16'h0000);
      tick();
      checkOutput("ill_done", {15'h0, done}, 16'h0001);
      checkOutput("ill_err", {15'h0, err}, 16'h0001);
      checkOutput("ill_result", result_data, 16'h0000);
      op_valid = 1'b0;
      tick();
      checkOutput("ign_ready", {15'h0, op_ready}, 16'h0001);
      tick();
      checkOutput("ign_strobes", strobes(), 16'h0000);
      checkOutput("ign_ready2", {15'h0, op_ready}, 16'h0001);
      checkOutput("ign_sp", sp_value, expPushSp);

      $display("[TB] reset during POP wait");
      mem_out = 16'hDEAD;
      applyStimulus(3'd1, 16'h0000);
      checkOutput("rpop_strobes", strobes(), 16'h0004);
      tick();
      #2;
      reset = 1'b1;
      #1;
      checkOutput("ramid_strobes", strobes(), 16'h0000);
      checkOutput("ramid_done", {15'h0, done}, 16'h0000);
      checkOutput("ramid_sp", sp_value, 16'hFFFF);
      checkOutput("ramid_mid", mem_input_data, 16'hFFFF);
      checkOutput("ramid_result", result_data, 16'h0000);
      repeat (2) begin
         tick();
         checkOutput("rhold_done", {15'h0, done}, 16'h0000);
      end
      reset = 1'b0;
      tick();
      checkOutput("rsync_strobes", strobes(), 16'h0001);
      checkOutput("rsync_done", {15'h0, done}, 16'h0000);
      tick();
      checkOutput("ridle_ready", {15'h0, op_ready}, 16'h0001);
      checkOutput("ridle_done", {15'h0, done}, 16'h0000);
      checkOutput("ridle_sp", sp_value, 16'hFFFF);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
